// File: rtl/sig_gen_pkg.sv
// Shared types and defaults for the sig_gen waveform sequencer.
package sig_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_DIV_W  = 16;

endpackage

// File: rtl/sig_gen_if.sv
// Control/table/DAC bundle between the control FSM (master) and sig_gen_seq (slave).
interface sig_gen_if
    import sig_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DIV_W  = DEF_DIV_W
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    // No valid/ready: wr_en, start and stop are levels sampled on every falling
    // clock edge; the sequencer never back-pressures, so each sampled level acts.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   cfg_len;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [DATA_W-1:0] cfg_idle;
    logic              start;
    logic              stop;

    logic [DATA_W-1:0] sg_out;
    logic              busy;
    logic              done;
    logic              wrap;
    logic [ADDR_W-1:0] idx_out;
    state_e            state_dbg;

    modport master (
        output wr_en, wr_addr, wr_data, cfg_len, cfg_div, cfg_mode, cfg_idle, start, stop,
        input  sg_out, busy, done, wrap, idx_out, state_dbg
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, cfg_len, cfg_div, cfg_mode, cfg_idle, start, stop,
        output sg_out, busy, done, wrap, idx_out, state_dbg
    );

endinterface

// File: rtl/sig_gen_hold_cnt.sv
// Per-point hold down-counter: load has priority, decrement saturates at zero.
module sig_gen_hold_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Falling edge: the DAC latches sg_out on the rising edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sig_gen_seq.sv
// DAC waveform sequencer: plays table entries 0..len-1, each held div+1 clocks,
// one-shot or continuous. All state moves on the falling edge of clk.
module sig_gen_seq
    import sig_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic     clk,
    input  logic     rst,
    sig_gen_if.slave sg
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sg_out_q, sg_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              mode_q, mode_d;

    logic              hold_load;
    logic              hold_dec;
    logic              hold_zero;
    logic [DIV_W-1:0]  hold_val;
    logic [ADDR_W-1:0] idx_nxt;
    logic [LEN_W-1:0]  len_clamped;
    logic              last_pt;

    // Table is deliberately not reset; reads in the same cycle see the old word.
    always_ff @(negedge clk) begin
        if (sg.wr_en && ({1'b0, sg.wr_addr} < DEPTH_L)) begin
            mem_q[sg.wr_addr] <= sg.wr_data;
        end
    end

    assign len_clamped = ((sg.cfg_len == '0) || (sg.cfg_len > DEPTH_L)) ? DEPTH_L : sg.cfg_len;
    assign idx_nxt     = idx_q + ADDR_W'(1);
    // Compare in LEN_W bits so that len == DEPTH does not wrap the index.
    assign last_pt     = (({1'b0, idx_q} + LEN_W'(1)) >= len_q);

    sig_gen_hold_cnt #(
        .DIV_W (DIV_W)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hold_load),
        .load_val_i (hold_val),
        .dec_i      (hold_dec),
        .zero_o     (hold_zero)
    );

    always_comb begin
        state_d   = state_q;
        sg_out_d  = sg_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        idx_d     = idx_q;
        len_d     = len_q;
        div_d     = div_q;
        mode_d    = mode_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        hold_val  = div_q;

        case (state_q)
            IDLE: begin
                sg_out_d = sg.cfg_idle;
                if (sg.start && !sg.stop) begin
                    state_d   = RUN;
                    sg_out_d  = mem_q[0];
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    len_d     = len_clamped;
                    div_d     = sg.cfg_div;
                    mode_d    = sg.cfg_mode;
                    hold_load = 1'b1;
                    hold_val  = sg.cfg_div;
                end
            end
            RUN: begin
                if (sg.stop) begin
                    state_d  = IDLE;
                    sg_out_d = sg.cfg_idle;
                    busy_d   = 1'b0;
                end else if (!hold_zero) begin
                    hold_dec = 1'b1;
                end else if (!last_pt) begin
                    idx_d     = idx_nxt;
                    sg_out_d  = mem_q[idx_nxt];
                    hold_load = 1'b1;
                end else if (mode_q == MODE_ONESHOT) begin
                    state_d  = IDLE;
                    sg_out_d = sg.cfg_idle;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    idx_d     = '0;
                    sg_out_d  = mem_q[0];
                    hold_load = 1'b1;
                    wrap_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sg_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            idx_q    <= '0;
            len_q    <= DEPTH_L;
            div_q    <= '0;
            mode_q   <= MODE_ONESHOT;
        end else begin
            state_q  <= state_d;
            sg_out_q <= sg_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
        end
    end

    assign sg.sg_out    = sg_out_q;
    assign sg.busy      = busy_q;
    assign sg.done      = done_q;
    assign sg.wrap      = wrap_q;
    assign sg.idx_out   = idx_q;
    assign sg.state_dbg = state_q;

endmodule

// File: tb/tb_sig_gen_seq.sv
// Bench for sig_gen_seq: time-since-start reference model, scenario tasks, random soak.
module tb_sig_gen_seq;

  localparam int DW = 12;
  localparam int DP = 8;
  localparam int VW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sig_gen_if #(.DATA_W(DW), .DEPTH(DP), .DIV_W(VW)) bus ();

  sig_gen_seq #(.DATA_W(DW), .DEPTH(DP), .DIV_W(VW)) dut (
    .clk (clk),
    .rst (rst),
    .sg  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: playback described as elapsed clocks since the start edge.
  logic [DW-1:0] m_mem [DP];
  bit            m_run;
  int            m_t, m_len, m_div;
  bit            m_mode;
  logic [DW-1:0] e_sg;
  logic          e_busy, e_done, e_wrap;
  logic [2:0]    e_idx;

  task automatic model_step();
    int per, tt;
    if (rst) begin
      m_run = 0; e_sg = '0; e_busy = 0; e_done = 0; e_wrap = 0; e_idx = '0;
    end else begin
      e_done = 0;
      e_wrap = 0;
      if (!m_run) begin
        if (bus.start && !bus.stop) begin
          m_run  = 1;
          m_t    = 0;
          m_len  = (bus.cfg_len == 0 || bus.cfg_len > DP) ? DP : int'(bus.cfg_len);
          m_div  = int'(bus.cfg_div);
          m_mode = bus.cfg_mode;
          e_sg   = m_mem[0];
          e_idx  = '0;
          e_busy = 1;
        end else begin
          e_sg = bus.cfg_idle;
        end
      end else if (bus.stop) begin
        m_run = 0; e_sg = bus.cfg_idle; e_busy = 0;
      end else begin
        m_t++;
        per = m_len * (m_div + 1);
        if (!m_mode && m_t == per) begin
          m_run = 0; e_sg = bus.cfg_idle; e_busy = 0; e_done = 1;
        end else begin
          tt = m_t % per;
          if (tt % (m_div + 1) == 0) begin
            e_idx = 3'(tt / (m_div + 1));
            e_sg  = m_mem[e_idx];
          end
          e_wrap = m_mode && (tt == 0);
        end
      end
    end
    if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
  endtask

  // Clock/drive: inputs change at posedge, DUT and model advance at negedge.
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
  endtask

  function automatic string act_s();
    return $sformatf("sg=%h busy=%b done=%b wrap=%b idx=%0d",
                     bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out);
  endfunction

  function automatic string exp_s();
    return $sformatf("sg=%h busy=%b done=%b wrap=%b idx=%0d", e_sg, e_busy, e_done, e_wrap, e_idx);
  endfunction

  task automatic quiet_inputs();
    bus.wr_en = 0; bus.start = 0; bus.stop = 0;
  endtask

  task automatic write_entry(input int a, input logic [DW-1:0] d);
    bus.wr_en = 1; bus.wr_addr = 3'(a); bus.wr_data = d;
    cycle();
    bus.wr_en = 0;
  endtask

  task automatic set_cfg(input int len, input int div, input bit mode);
    bus.cfg_len = 4'(len); bus.cfg_div = 16'(div); bus.cfg_mode = mode;
  endtask

  task automatic test_reset();
    quiet_inputs();
    bus.wr_addr = '0; bus.wr_data = '0;
    set_cfg(8, 0, 0);
    bus.cfg_idle = 12'h800;
    rst = 1;
    cycle();
    cycle();
    n_vec++;
    if ({bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {12'h000, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL reset_state: got %s want sg=000 busy=0 done=0 wrap=0 idx=0", act_s());
    end
    rst = 0;
    cycle();
    n_vec++;
    if (bus.sg_out !== 12'h800 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: got %s want sg=800 busy=0", act_s());
    end
  endtask

  task automatic test_oneshot();
    int busy_cnt = 0, done_cnt = 0;
    for (int i = 0; i < DP; i++) write_entry(i, 12'(i * 'h100));
    set_cfg(8, 0, 0);
    bus.cfg_idle = 12'h800;
    bus.start = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      bus.start = 0;
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      n_vec++;
      if (i < 8 && bus.sg_out !== 12'(i * 'h100)) begin
        n_err++; $display("FAIL oneshot_point%0d: got sg=%h want %h", i, bus.sg_out, 12'(i * 'h100));
      end
      if (i == 8 && (bus.sg_out !== 12'h800 || bus.done !== 1'b1)) begin
        n_err++; $display("FAIL oneshot_end: got %s want sg=800 done=1", act_s());
      end
      if ({bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {e_sg, e_busy, e_done, e_wrap, e_idx}) begin
        n_err++; $display("FAIL oneshot cyc%0d: got %s want %s", i, act_s(), exp_s());
      end
    end
    n_vec++;
    if (busy_cnt != 8 || done_cnt != 1) begin
      n_err++; $display("FAIL oneshot_counts: got busy=%0d done=%0d want busy=8 done=1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_continuous();
    int wraps = 0, dones = 0;
    for (int i = 0; i < 3; i++) write_entry(i, 12'($urandom_range(0, 4095)));
    set_cfg(3, 2, 1);
    bus.cfg_idle = 12'($urandom_range(0, 4095));
    bus.start = 1;
    for (int i = 0; i <= 27; i++) begin
      cycle();
      bus.start = 0;
      wraps += int'(bus.wrap);
      dones += int'(bus.done);
      n_vec++;
      if (i > 0 && i % 9 == 0 && (bus.wrap !== 1'b1 || bus.sg_out !== m_mem[0])) begin
        n_err++; $display("FAIL cont_wrap t=%0d: got wrap=%b sg=%h want wrap=1 sg=%h", i, bus.wrap, bus.sg_out, m_mem[0]);
      end
      if ({bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {e_sg, e_busy, e_done, e_wrap, e_idx}) begin
        n_err++; $display("FAIL continuous t=%0d: got %s want %s", i, act_s(), exp_s());
      end
    end
    n_vec++;
    if (wraps != 3 || dones != 0) begin
      n_err++; $display("FAIL cont_counts: got wraps=%0d done=%0d want wraps=3 done=0", wraps, dones);
    end
    bus.stop = 1;
    cycle();
    bus.stop = 0;
  endtask

  task automatic test_stop();
    int div = $urandom_range(1, 4);
    set_cfg(4, div, 1);
    bus.cfg_idle = 12'($urandom_range(0, 4095));
    bus.start = 1;
    cycle();
    bus.start = 0;
    for (int i = 0; i < div + 1; i++) cycle();
    bus.stop = 1;
    cycle();
    bus.stop = 0;
    n_vec++;
    if ({bus.sg_out, bus.busy, bus.done, bus.wrap} !== {bus.cfg_idle, 1'b0, 1'b0, 1'b0}
        || {bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {e_sg, e_busy, e_done, e_wrap, e_idx}) begin
      n_err++; $display("FAIL stop_mid_hold: got %s want %s", act_s(), exp_s());
    end
  endtask

  task automatic test_clamp();
    int lens [2] = '{0, 9};
    for (int k = 0; k < 2; k++) begin
      int div = $urandom_range(0, 2);
      int busy_cnt = 0, done_cnt = 0;
      for (int i = 0; i < DP; i++) write_entry(i, 12'($urandom_range(0, 4095)));
      set_cfg(lens[k], div, 0);
      bus.start = 1;
      for (int i = 0; i < 8 * (div + 1) + 2; i++) begin
        cycle();
        bus.start = 0;
        if (i == 1) set_cfg(2, 7, 1);
        busy_cnt += int'(bus.busy);
        done_cnt += int'(bus.done);
        n_vec++;
        if ({bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {e_sg, e_busy, e_done, e_wrap, e_idx}) begin
          n_err++; $display("FAIL clamp len=%0d cyc%0d: got %s want %s", lens[k], i, act_s(), exp_s());
        end
      end
      n_vec++;
      if (busy_cnt != 8 * (div + 1) || done_cnt != 1) begin
        n_err++; $display("FAIL clamp_counts len=%0d: got busy=%0d done=%0d want busy=%0d done=1",
                          lens[k], busy_cnt, done_cnt, 8 * (div + 1));
      end
    end
  endtask

  task automatic test_collisions();
    logic [DW-1:0] nv;
    int seen5 = 0;
    set_cfg(4, 1, 0);
    bus.start = 1; bus.stop = 1;
    cycle();
    bus.stop = 0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.sg_out !== bus.cfg_idle) begin
      n_err++; $display("FAIL start_stop_idle: got %s want busy=0 sg=%h", act_s(), bus.cfg_idle);
    end
    // start held high through a whole run must not restart it
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_vec++;
      if ({bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {e_sg, e_busy, e_done, e_wrap, e_idx}) begin
        n_err++; $display("FAIL start_in_run cyc%0d: got %s want %s", i, act_s(), exp_s());
      end
    end
    bus.start = 0;
    cycle();
    cycle();
    nv = m_mem[5] ^ 12'($urandom_range(1, 4095));
    set_cfg(8, 2, 0);
    bus.start = 1;
    cycle();
    bus.start = 0;
    for (int i = 0; i < 26; i++) begin
      if (i == 3) begin bus.wr_en = 1; bus.wr_addr = 3'd5; bus.wr_data = nv; end
      cycle();
      bus.wr_en = 0;
      if (bus.busy && bus.idx_out == 3'd5) begin
        seen5++;
        n_vec++;
        if (bus.sg_out !== nv) begin
          n_err++; $display("FAIL write_in_play: got sg=%h want %h", bus.sg_out, nv);
        end
      end
      n_vec++;
      if ({bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {e_sg, e_busy, e_done, e_wrap, e_idx}) begin
        n_err++; $display("FAIL write_play cyc%0d: got %s want %s", i, act_s(), exp_s());
      end
    end
    n_vec++;
    if (seen5 != 3) begin
      n_err++; $display("FAIL write_in_play_cycles: got %0d want 3", seen5);
    end
  endtask

  task automatic test_reset_mid_run();
    set_cfg(8, 1, 0);
    bus.start = 1;
    cycle();
    bus.start = 0;
    for (int i = 0; i < 5; i++) cycle();
    rst = 1;
    cycle();
    rst = 0;
    n_vec++;
    if ({bus.sg_out, bus.busy, bus.done, bus.idx_out} !== {12'h000, 1'b0, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL reset_mid_run: got %s want sg=000 busy=0 done=0 idx=0", act_s());
    end
    cycle();
    bus.start = 1;
    for (int i = 0; i < 18; i++) begin
      cycle();
      bus.start = 0;
      n_vec++;
      if ({bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {e_sg, e_busy, e_done, e_wrap, e_idx}) begin
        n_err++; $display("FAIL replay_after_reset cyc%0d: got %s want %s", i, act_s(), exp_s());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.stop     = ($urandom_range(0, 19) == 0);
      bus.wr_en    = ($urandom_range(0, 7) == 0);
      bus.wr_addr  = 3'($urandom_range(0, 7));
      bus.wr_data  = 12'($urandom_range(0, 4095));
      bus.cfg_len  = 4'($urandom_range(0, 15));
      bus.cfg_div  = 16'($urandom_range(0, 3));
      bus.cfg_mode = 1'($urandom_range(0, 1));
      bus.cfg_idle = 12'($urandom_range(0, 4095));
      rst          = ($urandom_range(0, 99) == 0);
      cycle();
      n_vec++;
      if ({bus.sg_out, bus.busy, bus.done, bus.wrap, bus.idx_out} !== {e_sg, e_busy, e_done, e_wrap, e_idx}) begin
        n_err++; $display("FAIL random cyc%0d: got %s want %s", i, act_s(), exp_s());
      end
    end
    rst = 0;
    quiet_inputs();
  endtask

  initial begin
    @(posedge clk);
    test_reset();
    test_oneshot();
    test_continuous();
    test_stop();
    test_clamp();
    test_collisions();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sig_gen_seq.md
Name: sig_gen_seq

Overview:
Parametrised DAC waveform sequencer, successor to the fixed 8-point signal generator. Holds a DEPTH-entry sample table written over a simple write port. On command it plays the first cfg_len entries to the DAC data bus, each held for cfg_div+1 clocks, in one-shot or continuous mode. Sits between the control FSM (table load, start/stop) and the parallel DAC.

Parameters:
DATA_W, 12, sample and DAC word width
DEPTH, 8, sample table entries (2..256)
ADDR_W, $clog2(DEPTH), table index width (derived, not overridden)
DIV_W, 16, hold-count width

Ports:
clk  in  1  system clock; all state updates on the falling edge because the DAC latches on the rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  table write index
wr_data  in  DATA_W  table write data
cfg_len  in  ADDR_W+1  number of points to play
cfg_div  in  DIV_W  extra hold clocks per point
cfg_mode  in  1  0 = one-shot, 1 = continuous
cfg_idle  in  DATA_W  DAC value when not playing
start  in  1  begin playback (level sampled each edge)
stop  in  1  abort playback
sg_out  out  DATA_W  DAC data, registered
busy  out  1  high while in RUN
done  out  1  1-clock pulse when one-shot playback completes
wrap  out  1  1-clock pulse on each continuous-mode wrap to entry 0
idx_out  out  ADDR_W  index of the entry currently on sg_out

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Every register updates on the falling edge of clk, including reset.
- Reset values: sg_out=0 (not cfg_idle), busy=0, done=0, wrap=0, idx_out=0, state=IDLE, hold counter=0. The table is not reset.
- Reset mid-RUN: abort on that edge, no done pulse.
- Table write: wr_en writes mem[wr_addr]<=wr_data in any state.
  - wr_addr>=DEPTH is ignored.
  - A write and a read of the same entry on one edge: sg_out takes the old data.
- Config latch: cfg_len, cfg_div and cfg_mode are latched on the start edge. Changes during RUN have no effect.
  - cfg_len=0 or cfg_len>DEPTH is clamped to DEPTH.
  - cfg_idle is used live, not latched.
- States: IDLE and RUN.
- IDLE:
  - sg_out<=cfg_idle each edge (except the reset edge).
  - Edge with start=1 and stop=0: state<=RUN, sg_out<=mem[0], idx_out<=0, hold<=cfg_div, busy<=1. Zero latency: the first point appears on the start edge.
  - start and stop together in IDLE: stop wins, stay IDLE.
- RUN, each edge:
  - stop=1: state<=IDLE, sg_out<=cfg_idle, busy<=0. No done, no wrap.
  - Else if hold!=0: hold<=hold-1 and sg_out is held.
  - Else if idx_out<len-1: idx_out<=idx_out+1, sg_out<=mem[idx_out+1], hold<=div.
  - Else (last point finished), one-shot: state<=IDLE, sg_out<=cfg_idle, busy<=0, done<=1.
  - Else (last point finished), continuous: idx_out<=0, sg_out<=mem[0], hold<=div, wrap<=1. No gap cycle.
  - start in RUN is ignored (no restart).
- Pulses: done and wrap are 1-clock pulses, otherwise 0.
- Timing: every table entry 0..len-1 is output, including the last. Each point lasts exactly div+1 clocks. A one-shot run occupies len*(div+1) clocks of busy.
- Arithmetic: hold counter is DIV_W wide and unsigned. Index compare uses ADDR_W+1 bits so that len=DEPTH works without overflow.

Decomposition:
- Package sig_gen_pkg:
  - state enum {IDLE, RUN}
  - mode constants MODE_ONESHOT=1'b0, MODE_CONT=1'b1
  - default widths
- Sub-module sig_gen_hold_cnt: DIV_W down-counter with load and zero flag. Natural to split out; the rest stays in sig_gen_seq.

Test Plan:
1. Reset, load mem[i]=i*0x100, len=8, div=0, one-shot, idle=0x800, pulse start. Required: sg_out = 0x000, 0x100 … 0x700 on 8 consecutive edges starting at the start edge; then 0x800 with done=1 for one clock; busy high exactly 8 clocks.
2. len=3, div=2, continuous. Required: each of mem0..mem2 held 3 clocks; wrap=1 on every 9th clock, coinciding with mem0 reappearing; no done.
3. Continuous run, assert stop mid-hold of point 1. Required: next edge sg_out=cfg_idle, busy=0, done=0, wrap=0.
4. cfg_len=0 and cfg_len=DEPTH+1 with DEPTH=8. Required: both play all 8 points. Changing cfg_len, cfg_div or cfg_mode during RUN has no effect.
5. start and stop together in IDLE: stays IDLE. start during RUN: sequence continues unchanged. wr_en to mem[5] during play: new value appears when index 5 is next output. wr_addr=9 with DEPTH=8: table unchanged.
6. Assert rst mid-RUN. Required: next edge sg_out=0, busy=0, idx_out=0, no done. A subsequent start replays from mem[0] using the retained table contents.
